// File: rtl/irq_pkg.sv
// Shared types and constants for the external-interrupt priority arbiter.
// The IRQ_EDGE_EN build option is consumed in irq_gateway.
package irq_pkg;

    typedef enum logic [1:0] {
        GW_IDLE       = 2'd0,
        GW_PENDING    = 2'd1,
        GW_IN_SERVICE = 2'd2
    } gw_state_t;

    typedef enum logic [1:0] {
        CFG_PRIO = 2'd0,
        CFG_EN   = 2'd1,
        CFG_THR  = 2'd2,
        CFG_RSVD = 2'd3
    } cfg_sel_t;

    // mcause code the trap controller reports for a machine external interrupt
    localparam logic [3:0] MCAUSE_MEI = 4'b1011;

endpackage

// File: rtl/irq_priority_arbiter_if.sv
// Bundle of source, config, claim/complete and status signals between the
// trap handler side (master) and the arbiter (slave).
interface irq_priority_arbiter_if #(
    parameter int N_SRC  = 8,
    parameter int PRIO_W = 3,
    parameter int ID_W   = $clog2(N_SRC + 1)
);
    logic [N_SRC-1:0]  i_src_irq;
    logic              i_cfg_we;
    logic [1:0]        i_cfg_sel;
    logic [ID_W-1:0]   i_cfg_idx;
    logic [PRIO_W-1:0] i_cfg_wdata;
    logic              i_claim;
    logic              o_claim_vld;
    logic [ID_W-1:0]   o_claim_id;
    logic              i_complete;
    logic [ID_W-1:0]   i_complete_id;
    logic              o_meip;
    logic [ID_W-1:0]   o_best_id;

    modport master (
        output i_src_irq, i_cfg_we, i_cfg_sel, i_cfg_idx, i_cfg_wdata,
        output i_claim, i_complete, i_complete_id,
        input  o_claim_vld, o_claim_id, o_meip, o_best_id
    );

    modport slave (
        input  i_src_irq, i_cfg_we, i_cfg_sel, i_cfg_idx, i_cfg_wdata,
        input  i_claim, i_complete, i_complete_id,
        output o_claim_vld, o_claim_id, o_meip, o_best_id
    );
endinterface

// File: rtl/irq_gateway.sv
// Per-source pending/in-service gateway. Level-triggered by default;
// define IRQ_EDGE_EN for rising-edge requests with a 1-deep "again" flag.
module irq_gateway
    import irq_pkg::*;
(
    input  logic      i_clk,
    input  logic      i_rst_n,
    input  logic      i_req,
    input  logic      i_claim_hit,
    input  logic      i_complete_hit,
    output gw_state_t o_state
);

`ifdef IRQ_EDGE_EN
    logic req_q;
    logic again;
    logic req_edge;

    assign req_edge = i_req & ~req_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_state <= GW_IDLE;
            req_q   <= 1'b0;
            again   <= 1'b0;
        end else begin
            req_q <= i_req;
            case (o_state)
                GW_IDLE:       if (req_edge) o_state <= GW_PENDING;
                GW_PENDING:    if (i_claim_hit) o_state <= GW_IN_SERVICE;
                GW_IN_SERVICE: begin
                    // an edge coinciding with complete counts as the re-arm
                    if (i_complete_hit) begin
                        o_state <= (again | req_edge) ? GW_PENDING : GW_IDLE;
                        again   <= 1'b0;
                    end else if (req_edge) begin
                        again <= 1'b1;
                    end
                end
                default:       o_state <= GW_IDLE;
            endcase
        end
    end
`else
    always_ff @(posedge i_clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (!i_rst_n) begin
            o_state <= GW_IDLE;
        end else begin
            case (o_state)
                GW_IDLE:       if (i_req) o_state <= GW_PENDING;
                GW_PENDING:    if (i_claim_hit) o_state <= GW_IN_SERVICE;
                GW_IN_SERVICE: if (i_complete_hit) o_state <= GW_IDLE;
                default:       o_state <= GW_IDLE;
            endcase
        end
    end
`endif

endmodule

// File: rtl/irq_priority_arbiter.sv
// PLIC-lite priority arbiter: config registers, per-source gateways, priority
// tree, registered winner/meip and claim response. Build option: IRQ_EDGE_EN.
module irq_priority_arbiter
    import irq_pkg::*;
#(
    parameter int N_SRC  = 8,
    parameter int PRIO_W = 3
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    irq_priority_arbiter_if.slave bus
);
    localparam int ID_W = $clog2(N_SRC + 1);

    logic [PRIO_W-1:0] prio [N_SRC];
    logic [N_SRC-1:0]  en;
    logic [PRIO_W-1:0] thr;

    gw_state_t         gw_state [N_SRC];
    logic [N_SRC-1:0]  eligible;
    logic [N_SRC-1:0]  claim_hit;
    logic [N_SRC-1:0]  complete_hit;

    logic [PRIO_W-1:0] win_prio;
    logic [ID_W-1:0]   win_id;
    logic [ID_W-1:0]   best_id_q;
    logic              meip_q;
    logic              claim_vld_q;
    logic [ID_W-1:0]   claim_id_q;
    logic              claim_accept;

    // a claim pulse arriving during the response cycle is dropped
    assign claim_accept = bus.i_claim & ~claim_vld_q;

    always_ff @(posedge i_clk) begin
        // NOTE: the config array is reset as well: it is software-visible
        // state that must read back as zero, not a data buffer.
        if (!i_rst_n) begin
            for (int k = 0; k < N_SRC; k++) prio[k] <= '0;
            en  <= '0;
            thr <= '0;
        end else if (bus.i_cfg_we) begin
            for (int k = 0; k < N_SRC; k++) begin
                if (bus.i_cfg_idx == ID_W'(k + 1)) begin
                    if (bus.i_cfg_sel == CFG_PRIO) prio[k] <= bus.i_cfg_wdata;
                    if (bus.i_cfg_sel == CFG_EN)   en[k]   <= bus.i_cfg_wdata[0];
                end
            end
            if (bus.i_cfg_sel == CFG_THR) thr <= bus.i_cfg_wdata;
        end
    end

    for (genvar k = 0; k < N_SRC; k++) begin : g_src
        assign claim_hit[k]    = claim_accept & (best_id_q == ID_W'(k + 1));
        assign complete_hit[k] = bus.i_complete & (bus.i_complete_id == ID_W'(k + 1));
        assign eligible[k]     = (gw_state[k] == GW_PENDING) & en[k] & (prio[k] > thr);

        irq_gateway u_gw (
            .i_clk          (i_clk),
            .i_rst_n        (i_rst_n),
            .i_req          (bus.i_src_irq[k]),
            .i_claim_hit    (claim_hit[k]),
            .i_complete_hit (complete_hit[k]),
            .o_state        (gw_state[k])
        );
    end

    always_comb begin
        // NOTE: defaults first so no path through the loop leaves a latch.
        win_prio = '0;
        win_id   = '0;
        // strict '>' keeps the lowest id on equal priority
        for (int k = 0; k < N_SRC; k++) begin
            if (eligible[k] && (prio[k] > win_prio)) begin
                win_prio = prio[k];
                win_id   = ID_W'(k + 1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            best_id_q   <= '0;
            meip_q      <= 1'b0;
            claim_vld_q <= 1'b0;
            claim_id_q  <= '0;
        end else begin
            best_id_q   <= win_id;
            meip_q      <= (win_id != '0);
            claim_vld_q <= claim_accept;
            claim_id_q  <= claim_accept ? best_id_q : '0;
        end
    end

    assign bus.o_best_id   = best_id_q;
    assign bus.o_meip      = meip_q;
    assign bus.o_claim_vld = claim_vld_q;
    assign bus.o_claim_id  = claim_id_q;

endmodule

// File: tb/tb_irq_priority_arbiter.sv
// Directed bench for irq_priority_arbiter; expectations follow the IRQ_EDGE_EN
// setting of the build.
module tb_irq_priority_arbiter;
    import irq_pkg::*;

    localparam int N_SRC  = 8;
    localparam int PRIO_W = 3;
    localparam int ID_W   = $clog2(N_SRC + 1);

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    irq_priority_arbiter_if #(.N_SRC(N_SRC), .PRIO_W(PRIO_W)) bus ();

    irq_priority_arbiter #(.N_SRC(N_SRC), .PRIO_W(PRIO_W)) u_dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance past one rising edge; inputs change and outputs are sampled here
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_src_irq     = '0;
        bus.i_cfg_we      = 1'b0;
        bus.i_cfg_sel     = 2'd0;
        bus.i_cfg_idx     = '0;
        bus.i_cfg_wdata   = '0;
        bus.i_claim       = 1'b0;
        bus.i_complete    = 1'b0;
        bus.i_complete_id = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic cfg_write(input logic [1:0] sel, input int idx, input int data);
        bus.i_cfg_we    = 1'b1;
        bus.i_cfg_sel   = sel;
        bus.i_cfg_idx   = ID_W'(idx);
        bus.i_cfg_wdata = PRIO_W'(data);
        tick();
        bus.i_cfg_we    = 1'b0;
    endtask

    task automatic do_claim();
        bus.i_claim = 1'b1;
        tick();
        bus.i_claim = 1'b0;
    endtask

    task automatic do_complete(input int id);
        bus.i_complete    = 1'b1;
        bus.i_complete_id = ID_W'(id);
        tick();
        bus.i_complete    = 1'b0;
        bus.i_complete_id = '0;
    endtask

    task automatic test_reset_and_single();
        rst_n = 1'b1;
        idle_inputs();
        tick();
        do_reset();
        checks++;
        if ({bus.o_meip, bus.o_claim_vld, bus.o_best_id, bus.o_claim_id} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got meip=%0b vld=%0b best=%0d cid=%0d expected all 0",
                     bus.o_meip, bus.o_claim_vld, bus.o_best_id, bus.o_claim_id);
        end
        cfg_write(CFG_PRIO, 3, 5);
        cfg_write(CFG_EN, 3, 1);
        cfg_write(CFG_THR, 0, 0);
        bus.i_src_irq[2] = 1'b1;
        tick();
        checks++;
        if (bus.o_meip !== 1'b0) begin
            failures++;
            $display("FAIL single_meip_edge1: got %0b expected 0", bus.o_meip);
        end
        tick();
        checks++;
        if (bus.o_meip !== 1'b1) begin
            failures++;
            $display("FAIL single_meip_edge2: got %0b expected 1", bus.o_meip);
        end
        checks++;
        if (bus.o_best_id !== 4'd3) begin
            failures++;
            $display("FAIL single_best: got %0d expected 3", bus.o_best_id);
        end
    endtask

    task automatic test_priority_tie();
        do_reset();
        cfg_write(CFG_PRIO, 2, 4);
        cfg_write(CFG_PRIO, 5, 4);
        cfg_write(CFG_EN, 2, 1);
        cfg_write(CFG_EN, 5, 1);
        bus.i_src_irq[1] = 1'b1;
        bus.i_src_irq[4] = 1'b1;
        tick();
        tick();
        bus.i_src_irq = '0;
        checks++;
        if (bus.o_best_id !== 4'd2) begin
            failures++;
            $display("FAIL tie_best: got %0d expected 2", bus.o_best_id);
        end
        do_claim();
        checks++;
        if (bus.o_claim_vld !== 1'b1 || bus.o_claim_id !== 4'd2) begin
            failures++;
            $display("FAIL tie_claim: got vld=%0b id=%0d expected vld=1 id=2",
                     bus.o_claim_vld, bus.o_claim_id);
        end
        tick();
        checks++;
        if (bus.o_best_id !== 4'd5 || bus.o_claim_vld !== 1'b0) begin
            failures++;
            $display("FAIL tie_next_best: got best=%0d vld=%0b expected best=5 vld=0",
                     bus.o_best_id, bus.o_claim_vld);
        end
        do_complete(2);
        do_claim();
        checks++;
        if (bus.o_claim_vld !== 1'b1 || bus.o_claim_id !== 4'd5) begin
            failures++;
            $display("FAIL tie_claim5: got vld=%0b id=%0d expected vld=1 id=5",
                     bus.o_claim_vld, bus.o_claim_id);
        end
        tick();
        checks++;
        if (bus.o_best_id !== 4'd0 || bus.o_meip !== 1'b0) begin
            failures++;
            $display("FAIL tie_drained: got best=%0d meip=%0b expected best=0 meip=0",
                     bus.o_best_id, bus.o_meip);
        end
    endtask

    task automatic test_empty_claim();
        do_reset();
        bus.i_claim = 1'b1;
        tick();
        checks++;
        if (bus.o_claim_vld !== 1'b1 || bus.o_claim_id !== 4'd0) begin
            failures++;
            $display("FAIL empty_claim: got vld=%0b id=%0d expected vld=1 id=0",
                     bus.o_claim_vld, bus.o_claim_id);
        end
        tick();
        bus.i_claim = 1'b0;
        checks++;
        if (bus.o_claim_vld !== 1'b0) begin
            failures++;
            $display("FAIL back_to_back_claim: got vld=%0b expected 0", bus.o_claim_vld);
        end
    endtask

    task automatic test_again();
        logic       exp_meip;
        logic [3:0] exp_best;
`ifdef IRQ_EDGE_EN
        exp_meip = 1'b1;
        exp_best = 4'd4;
`else
        exp_meip = 1'b0;
        exp_best = 4'd0;
`endif
        do_reset();
        cfg_write(CFG_PRIO, 4, 2);
        cfg_write(CFG_EN, 4, 1);
        bus.i_src_irq[3] = 1'b1;
        tick();
        tick();
        do_claim();
        checks++;
        if (bus.o_claim_id !== 4'd4) begin
            failures++;
            $display("FAIL again_claim: got %0d expected 4", bus.o_claim_id);
        end
        bus.i_src_irq[3] = 1'b0;
        tick();
        bus.i_src_irq[3] = 1'b1;
        tick();
        bus.i_src_irq[3] = 1'b0;
        tick();
        checks++;
        if (bus.o_meip !== 1'b0) begin
            failures++;
            $display("FAIL again_in_service: got meip=%0b expected 0", bus.o_meip);
        end
        do_complete(4);
        tick();
        checks++;
        if (bus.o_meip !== exp_meip || bus.o_best_id !== exp_best) begin
            failures++;
            $display("FAIL again_after_complete: got meip=%0b best=%0d expected meip=%0b best=%0d",
                     bus.o_meip, bus.o_best_id, exp_meip, exp_best);
        end
    endtask

    task automatic test_threshold();
        do_reset();
        cfg_write(CFG_PRIO, 1, 7);
        cfg_write(CFG_EN, 1, 1);
        cfg_write(CFG_THR, 0, 7);
        bus.i_src_irq[0] = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.o_meip !== 1'b0) begin
            failures++;
            $display("FAIL thr_masked: got meip=%0b expected 0", bus.o_meip);
        end
        cfg_write(CFG_THR, 0, 6);
        checks++;
        if (bus.o_meip !== 1'b0) begin
            failures++;
            $display("FAIL thr_write_edge: got meip=%0b expected 0", bus.o_meip);
        end
        tick();
        checks++;
        if (bus.o_meip !== 1'b1 || bus.o_best_id !== 4'd1) begin
            failures++;
            $display("FAIL thr_unmasked: got meip=%0b best=%0d expected meip=1 best=1",
                     bus.o_meip, bus.o_best_id);
        end
        do_complete(9);
        tick();
        checks++;
        if (bus.o_meip !== 1'b1 || bus.o_best_id !== 4'd1) begin
            failures++;
            $display("FAIL complete_bad_id: got meip=%0b best=%0d expected meip=1 best=1",
                     bus.o_meip, bus.o_best_id);
        end
        cfg_write(CFG_THR, 0, 7);
        checks++;
        if (bus.o_meip !== 1'b1) begin
            failures++;
            $display("FAIL thr_all_ones_edge: got meip=%0b expected 1", bus.o_meip);
        end
        tick();
        checks++;
        if (bus.o_meip !== 1'b0) begin
            failures++;
            $display("FAIL thr_all_ones_fall: got meip=%0b expected 0", bus.o_meip);
        end
    endtask

    task automatic test_reset_in_flight();
        do_reset();
        cfg_write(CFG_PRIO, 6, 3);
        cfg_write(CFG_EN, 6, 1);
        bus.i_src_irq[5] = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.o_best_id !== 4'd6) begin
            failures++;
            $display("FAIL rst_pre_best: got %0d expected 6", bus.o_best_id);
        end
        bus.i_claim      = 1'b1;
        bus.i_src_irq[5] = 1'b0;
        rst_n            = 1'b0;
        tick();
        rst_n       = 1'b1;
        bus.i_claim = 1'b0;
        checks++;
        if ({bus.o_meip, bus.o_claim_vld, bus.o_best_id, bus.o_claim_id} !== '0) begin
            failures++;
            $display("FAIL rst_in_flight: got meip=%0b vld=%0b best=%0d cid=%0d expected all 0",
                     bus.o_meip, bus.o_claim_vld, bus.o_best_id, bus.o_claim_id);
        end
        tick();
        tick();
        checks++;
        if (bus.o_meip !== 1'b0 || bus.o_claim_vld !== 1'b0) begin
            failures++;
            $display("FAIL rst_gateways_idle: got meip=%0b vld=%0b expected 0 0",
                     bus.o_meip, bus.o_claim_vld);
        end
        bus.i_src_irq[5] = 1'b1;
        tick();
        tick();
        tick();
        checks++;
        if (bus.o_best_id !== 4'd0) begin
            failures++;
            $display("FAIL rst_cfg_cleared: got best=%0d expected 0", bus.o_best_id);
        end
        bus.i_src_irq = '0;
    endtask

    initial begin
        test_reset_and_single();
        test_priority_tie();
        test_empty_claim();
        test_again();
        test_threshold();
        test_reset_in_flight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
